// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header size and parser state encoding for the UART ALU packet parser.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;

  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_OPERAND,
    S_RESULT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/uart_alu_packet_parser_if.sv
// Byte streams between uart_rx, the packet parser and uart_tx.
// A byte moves on a rising clock edge where valid && ready; valid/data hold until ready is seen.
interface uart_alu_packet_parser_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;

  modport slave (
    input  s_data_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o
  );

  modport master (
    output s_data_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o
  );
endinterface

// File: rtl/uart_alu_word_serializer.sv
// Sends a loaded OPERAND_W word LS byte first over a valid/ready byte stream;
// done_o pulses in the cycle the last byte is accepted.
module uart_alu_word_serializer #(
  parameter int OPERAND_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [OPERAND_W-1:0] word_i,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 done_o
);
  localparam int NB    = OPERAND_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [OPERAND_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_o  = 1'b0;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      if (cnt_q == CNT_W'(NB - 1)) begin
        valid_d = 1'b0;
        done_o  = 1'b1;
      end else begin
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = shift_q[7:0];
  assign valid_o = valid_q;
endmodule

// File: rtl/uart_alu_packet_parser.sv
// Length-prefixed packet processor: echoes payload or reduces operand words with ADD/MUL.
// Optional feature macro: UART_ALU_MUL_EN enables opcode 0x88 (MUL); otherwise 0x88 is unknown.
module uart_alu_packet_parser
  import uart_alu_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int OPERAND_W = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  uart_alu_packet_parser_if.slave       bus,
  output logic                          busy_o,
  output logic                          err_o,
  output state_e                        dbg_state_o
);
  localparam int NB   = OPERAND_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [OPERAND_W-1:0] acc_q, acc_d;
  logic [OPERAND_W-1:0] word_q, word_d;
  logic [BC_W-1:0]      bcnt_q, bcnt_d;
  logic                 first_q, first_d;
  logic                 err_q, err_d;
  logic [7:0]           echo_data_q, echo_data_d;
  logic                 echo_valid_q, echo_valid_d;

  logic                 s_ready, s_fire, op_known;
  logic [LEN_W-1:0]     len_full, rem_new;
  logic [OPERAND_W-1:0] word_full;
  logic                 ser_load, ser_valid, ser_done;
  logic [7:0]           ser_data;

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: s_ready = 1'b1;
      S_ECHO:  s_ready = !echo_valid_q || bus.m_ready_i;
      default: s_ready = 1'b0;
    endcase
  end

  assign s_fire    = bus.s_valid_i && s_ready;
  assign len_full  = LEN_W'({bus.s_data_i, len_lo_q});
  assign rem_new   = len_full - LEN_W'(HDR_BYTES);
  assign word_full = {bus.s_data_i, word_q[OPERAND_W-1:8]};

`ifdef UART_ALU_MUL_EN
  assign op_known = (opcode_q == OP_ECHO) || (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
`else
  assign op_known = (opcode_q == OP_ECHO) || (opcode_q == OP_ADD);
`endif

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_lo_d     = len_lo_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    word_d       = word_q;
    bcnt_d       = bcnt_q;
    first_d      = first_q;
    err_d        = 1'b0;
    echo_data_d  = echo_data_q;
    echo_valid_d = echo_valid_q;
    ser_load     = 1'b0;

    // An echoed byte may still be waiting on uart_tx after the packet has ended.
    if (echo_valid_q && bus.m_ready_i) echo_valid_d = 1'b0;

    case (state_q)
      S_OPCODE: if (s_fire) begin
        opcode_d = bus.s_data_i;
        state_d  = S_RSVD;
      end
      S_RSVD: if (s_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (s_fire) begin
        len_lo_d = bus.s_data_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (s_fire) begin
        rem_d   = rem_new;
        bcnt_d  = '0;
        first_d = 1'b1;
        if (len_full <= LEN_W'(HDR_BYTES)) begin
          rem_d   = '0;
          state_d = S_OPCODE;
        end else if (!op_known) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (opcode_q == OP_ECHO) begin
          state_d = S_ECHO;
        end else if (rem_new < LEN_W'(HDR_BYTES)) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          state_d = S_OPERAND;
        end
      end
      S_ECHO: if (s_fire) begin
        echo_data_d  = bus.s_data_i;
        echo_valid_d = 1'b1;
        rem_d        = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = S_OPCODE;
      end
      S_OPERAND: if (s_fire) begin
        rem_d  = rem_q - LEN_W'(1);
        word_d = word_full;
        bcnt_d = bcnt_q + BC_W'(1);
        if (bcnt_q == BC_W'(NB - 1)) begin
          bcnt_d  = '0;
          first_d = 1'b0;
          if (first_q) acc_d = word_full;
`ifdef UART_ALU_MUL_EN
          else if (opcode_q == OP_MUL) acc_d = acc_q * word_full;
`endif
          else acc_d = acc_q + word_full;
        end
        if (rem_q == LEN_W'(1)) state_d = S_RESULT;
      end
      S_RESULT: begin
        // Start the serializer only once any leftover echo byte has left.
        ser_load = !ser_valid && !echo_valid_q;
        if (ser_done) state_d = S_OPCODE;
      end
      S_DRAIN: if (s_fire) begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = S_OPCODE;
      end
      default: state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_OPCODE;
      opcode_q     <= '0;
      len_lo_q     <= '0;
      rem_q        <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      bcnt_q       <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      echo_data_q  <= '0;
      echo_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_lo_q     <= len_lo_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      bcnt_q       <= bcnt_d;
      first_q      <= first_d;
      err_q        <= err_d;
      echo_data_q  <= echo_data_d;
      echo_valid_q <= echo_valid_d;
    end
  end

  uart_alu_word_serializer #(.OPERAND_W(OPERAND_W)) u_ser (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (ser_load),
    .word_i  (acc_q),
    .data_o  (ser_data),
    .valid_o (ser_valid),
    .ready_i (bus.m_ready_i),
    .done_o  (ser_done)
  );

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = echo_valid_q || ser_valid;
  assign bus.m_data_o  = echo_valid_q ? echo_data_q : ser_data;
  assign busy_o        = (state_q != S_OPCODE);
  assign err_o         = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_uart_alu_packet_parser.sv
// Scoreboard bench for uart_alu_packet_parser: directed packets plus random packets
// checked against a packet-level reference model.
module tb_uart_alu_packet_parser;
  import uart_alu_pkg::*;

  logic   clk_i = 1'b0;
  logic   rst_ni = 1'b0;
  logic   busy_o, err_o;
  state_e dbg_state;

  always #5 clk_i = ~clk_i;

  uart_alu_packet_parser_if bus ();

  uart_alu_packet_parser #(.LEN_W(16), .OPERAND_W(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state)
  );

  logic [7:0] exp_q[$];
  int exp_err = 0;
  int err_seen = 0;
  int checks = 0, errors = 0;
  int mon_checks = 0, mon_errors = 0;
  logic force_low = 1'b0;

  // ---------------- m_ready driver (random backpressure) ----------------
  initial begin
    bus.m_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      bus.m_ready_i = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    logic [7:0] exp;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pend = 1'b0;
      end else begin
        if (err_o) err_seen++;
        if (pend) begin
          mon_checks++;
          if (!bus.m_valid_o || bus.m_data_o !== pend_data) begin
            mon_errors++;
            $display("FAIL m_hold: valid=%0b data=%02h required valid=1 data=%02h",
                     bus.m_valid_o, bus.m_data_o, pend_data);
          end
        end
        if (bus.m_valid_o && bus.m_ready_i) begin
          mon_checks++;
          if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL m_byte: got %02h, required no output", bus.m_data_o);
          end else begin
            exp = exp_q.pop_front();
            if (bus.m_data_o !== exp) begin
              mon_errors++;
              $display("FAIL m_byte: got %02h, required %02h", bus.m_data_o, exp);
            end
          end
          pend = 1'b0;
        end else if (bus.m_valid_o) begin
          pend = 1'b1;
          pend_data = bus.m_data_o;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: whole-packet semantics, responses pushed before the bytes are sent.
  task automatic model(input logic [7:0] p[$]);
    int len, n;
    logic [31:0] acc, w;
    bit known;
    len = int'({p[3], p[2]});
    if (len <= 4) return;
    n = len - 4;
    known = (p[0] == 8'hEC) || (p[0] == 8'hAD);
`ifdef UART_ALU_MUL_EN
    if (p[0] == 8'h88) known = 1'b1;
`endif
    if (!known) begin
      exp_err++;
      return;
    end
    if (p[0] == 8'hEC) begin
      for (int i = 4; i < len; i++) exp_q.push_back(p[i]);
    end else if (n < 4) begin
      exp_err++;
    end else begin
      acc = '0;
      for (int k = 0; k < n / 4; k++) begin
        w = {p[4+4*k+3], p[4+4*k+2], p[4+4*k+1], p[4+4*k]};
        if (k == 0) acc = w;
        else if (p[0] == 8'hAD) acc = acc + w;
        else acc = acc * w;
      end
      for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = b;
    @(negedge clk_i);
    while (!bus.s_ready_o && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL s_accept: byte %02h not accepted within 500 cycles", b);
    end
    @(posedge clk_i);
    #1;
    bus.s_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[$]);
    model(p);
    foreach (p[i]) begin
      send_byte(p[i]);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic mk_pkt(input logic [7:0] op, input int len, output logic [7:0] p[$]);
    logic [15:0] l;
    l = 16'(len);
    p = {};
    p.push_back(op);
    p.push_back(8'($urandom));
    p.push_back(l[7:0]);
    p.push_back(l[15:8]);
    for (int i = 4; i < len; i++) p.push_back(8'($urandom));
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.m_valid_o || busy_o) && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    check({name, "_drain_timeout"}, int'(t >= 3000), 0);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check({name, "_err_count"}, err_seen, exp_err);
    check({name, "_busy_idle"}, int'(busy_o), 0);
    check({name, "_m_valid_idle"}, int'(bus.m_valid_o), 0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0] pkt[$];
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_m_valid", int'(bus.m_valid_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_s_ready", int'(bus.s_ready_o), 1);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // ECHO
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    send_pkt(pkt);
    wait_idle("echo");

    // ADD with wrap
    pkt = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt(pkt);
    wait_idle("add_wrap");

    // MUL (or unknown opcode when MUL is not built)
    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    wait_idle("mul");

    // Backpressure: uart_tx stalls with the first echoed byte pending
    pkt = '{8'hEC, 8'h00, 8'h09, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    model(pkt);
    for (int i = 0; i < 4; i++) send_byte(pkt[i]);
    force_low = 1'b1;
    @(posedge clk_i);
    #2;
    send_byte(pkt[4]);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = pkt[5];
    repeat (20) @(negedge clk_i);
    check("bp_s_ready", int'(bus.s_ready_o), 0);
    check("bp_m_valid", int'(bus.m_valid_o), 1);
    check("bp_m_data", int'(bus.m_data_o), int'(pkt[4]));
    @(posedge clk_i);
    #1;
    force_low = 1'b0;
    for (int i = 5; i < 9; i++) send_byte(pkt[i]);
    wait_idle("backpressure");

    // Error cases followed by a good packet
    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt(pkt);
    wait_idle("unknown_op");
    pkt = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02};
    send_pkt(pkt);
    wait_idle("short_add");
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h5A, 8'hA5, 8'h3C};
    send_pkt(pkt);
    wait_idle("echo_after_err");

    // Short lengths: header only, no response, no error
    pkt = '{8'h55, 8'h00, 8'h02, 8'h00};
    send_pkt(pkt);
    pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
    send_pkt(pkt);
    wait_idle("short_len");

    // Asynchronous reset in the middle of an ADD operand
    pkt = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02};
    foreach (pkt[i]) send_byte(pkt[i]);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_state", int'(dbg_state), int'(S_OPCODE));
    check("arst_busy", int'(busy_o), 0);
    check("arst_m_valid", int'(bus.m_valid_o), 0);
    check("arst_m_data", int'(bus.m_data_o), 0);
    check("arst_err", int'(err_o), 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40,
            8'h01, 8'h01, 8'h01, 8'h01};
    send_pkt(pkt);
    wait_idle("post_reset_add");

    // Randomized packets, including a length with a nonzero high byte
    for (int n = 0; n < 30; n++) begin
      logic [7:0] op;
      int len;
      case ($urandom_range(0, 3))
        0: op = 8'hEC;
        1: op = 8'hAD;
        2: op = 8'h88;
        default: op = 8'($urandom);
      endcase
      len = (n == 10) ? 261 : int'($urandom_range(0, 26));
      mk_pkt(op, len, pkt);
      send_pkt(pkt);
    end
    wait_idle("random");
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks + mon_checks, errors + mon_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors",
             checks + mon_checks + 1, errors + mon_errors + 1);
    $finish;
  end
endmodule
